regfile_dump_serializer: RTL and testbench



---
 rtl/regfile_dump_serializer.sv | 165 ++++++++++++++++
 tb/tb_regfile_dump_serializer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_serializer.sv
// Register-bank dump serializer: snapshots the debug bus on a start request and
// streams a framed byte sequence (header, data bytes MSB-first per register,
// XOR checksum) over a valid/ready byte interface toward a UART transmitter.
module regfile_dump_serializer #(
    parameter int         NUMBER_OF_REGISTERS = 32,
    parameter int         REGISTERS_SIZE      = 32,
    parameter logic [7:0] HEADER_BYTE         = 8'hA5
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset_n,
    input  logic                                          i_start,
    input  logic [NUMBER_OF_REGISTERS*REGISTERS_SIZE-1:0] i_Debugging,
    input  logic                                          i_tx_ready,
    output logic [7:0]                                    o_tx_data,
    output logic                                          o_tx_valid,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int BUS_W          = NUMBER_OF_REGISTERS * REGISTERS_SIZE;
    localparam int BYTES_PER_REG  = REGISTERS_SIZE / 8;
    localparam int BYTE_W         = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam int REG_W          = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_REG - 1);
    localparam logic [REG_W-1:0]  LAST_REG  = REG_W'(NUMBER_OF_REGISTERS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    // Which part of the frame the byte currently on o_tx_data belongs to.
    typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CSUM} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [BUS_W-1:0]    shadow_q, shadow_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [REG_W-1:0]    reg_idx_q, reg_idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BYTE_W-1:0]          fetch_byte;
    logic [REG_W-1:0]           fetch_reg;
    logic [REGISTERS_SIZE-1:0]  fetch_word;
    logic [7:0]                 fetch_data;

    // Position and value of the data byte that follows the one being presented.
    always_comb begin
        fetch_byte = '0;
        fetch_reg  = '0;
        if (phase_q == PH_HDR) begin
            fetch_byte = '0;
            fetch_reg  = '0;
        end else if (byte_idx_q == LAST_BYTE) begin
            fetch_byte = '0;
            fetch_reg  = reg_idx_q + REG_W'(1);
        end else begin
            fetch_byte = byte_idx_q + BYTE_W'(1);
            fetch_reg  = reg_idx_q;
        end
        fetch_word = shadow_q[int'(fetch_reg)*REGISTERS_SIZE +: REGISTERS_SIZE];
        fetch_data = fetch_word[(BYTES_PER_REG - 1 - int'(fetch_byte))*8 +: 8];
    end

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        reg_idx_d  = reg_idx_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d    = PH_HDR;
                byte_idx_d = '0;
                reg_idx_d  = '0;
                csum_d     = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                if (i_start) begin
                    shadow_d   = i_Debugging;
                    state_d    = SEND;
                    tx_data_d  = HEADER_BYTE;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    case (phase_q)
                        PH_HDR: begin
                            phase_d   = PH_DATA;
                            tx_data_d = fetch_data;
                        end
                        PH_DATA: begin
                            csum_d = csum_q ^ tx_data_q;
                            if (reg_idx_q == LAST_REG && byte_idx_q == LAST_BYTE) begin
                                phase_d   = PH_CSUM;
                                tx_data_d = csum_q ^ tx_data_q;
                            end else begin
                                byte_idx_d = fetch_byte;
                                reg_idx_d  = fetch_reg;
                                tx_data_d  = fetch_data;
                            end
                        end
                        default: begin
                            state_d    = DONE;
                            tx_data_d  = '0;
                            tx_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_HDR;
            shadow_q   <= '0;
            byte_idx_q <= '0;
            reg_idx_q  <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            reg_idx_q  <= reg_idx_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_regfile_dump_serializer.sv
// Directed testbench for regfile_dump_serializer at default parameters.
module tb_regfile_dump_serializer;

    localparam int NR    = 32;
    localparam int RS    = 32;
    localparam int BUS_W = NR * RS;
    localparam int FLEN  = 130;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [BUS_W-1:0] bus;
    logic             i_tx_ready;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             o_busy;
    logic             o_done;

    int vectors;
    int miscompares;

    logic [7:0] got [0:139];
    logic [7:0] exp_bytes [0:139];
    int n_got;
    int done_cnt;
    int busy_cyc;
    int unstable;

    regfile_dump_serializer dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_start     (i_start),
        .i_Debugging (bus),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame built from register words: header, MSB-first bytes, XOR.
    task automatic build_exp(input logic [BUS_W-1:0] b);
        logic [31:0] w;
        logic [7:0]  cs;
        logic [7:0]  by;
        cs = 8'h00;
        exp_bytes[0] = 8'hA5;
        for (int j = 0; j < NR; j++) begin
            w = b[j*RS +: RS];
            for (int k = 0; k < 4; k++) begin
                by = 8'(w >> (24 - 8*k));
                exp_bytes[1 + j*4 + k] = by;
                cs = cs ^ by;
            end
        end
        exp_bytes[FLEN-1] = cs;
    endtask

    // Pulse start for one edge; returns at the falling edge after the start edge.
    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Record accepted bytes at falling edges until o_done, a byte count or a cycle budget.
    // mode 0: ready always 1; mode 1: ready toggles 1/0.
    task automatic collect(input int mode, input int start_at, input int stop_at, input int max_cyc);
        logic       have_hold;
        logic [7:0] hold_val;
        n_got = 0; done_cnt = 0; busy_cyc = 0; unstable = 0; have_hold = 1'b0; hold_val = 8'h00;
        for (int c = 0; c < max_cyc; c++) begin
            if (stop_at > 0 && n_got == stop_at) break;
            i_tx_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (start_at >= 0) i_start = (n_got == start_at);
            if (have_hold && o_tx_data !== hold_val) unstable++;
            if (o_busy) busy_cyc++;
            if (o_done) begin
                done_cnt++;
                break;
            end
            if (o_tx_valid && i_tx_ready) begin
                if (n_got < 140) got[n_got] = o_tx_data;
                n_got++;
                have_hold = 1'b0;
            end else if (o_tx_valid) begin
                have_hold = 1'b1;
                hold_val  = o_tx_data;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name);
        int bad;
        int first;
        bad = 0; first = -1;
        for (int i = 0; i < FLEN; i++) begin
            if (got[i] !== exp_bytes[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (bad != 0 || n_got != FLEN || done_cnt != 1) begin
            miscompares++;
            if (first >= 0)
                $display("FAIL %s: %0d bytes, done=%0d, byte[%0d]=%02h expected %02h (%0d bad)",
                         name, n_got, done_cnt, first, got[first], exp_bytes[first], bad);
            else
                $display("FAIL %s: %0d bytes done=%0d, expected %0d bytes done=1", name, n_got, done_cnt, FLEN);
        end else
            $display("%s: 130 bytes, checksum %02h", name, got[FLEN-1]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_tx_ready = 1'b0; bus = '0;
        #12;
        vectors++;
        if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %03h expected 000", {o_tx_data, o_tx_valid, o_busy, o_done});
        end else $display("reset_state: outputs 0");
        @(negedge clk);
        rst_n = 1'b1;
        bus = '0;
        bus[1*RS +: RS] = 32'hDEADBEEF;
        pulse_start();
        i_tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (o_tx_valid !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_active: valid=%b busy=%b expected 1 1", o_tx_valid, o_busy);
        end else $display("pre_reset_active: valid=1 busy=1");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %03h expected 000", {o_tx_data, o_tx_valid, o_busy, o_done});
        end else $display("async_reset: outputs 0 without edge");
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_done || o_busy) done_cnt++;
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: %0d done/busy cycles expected 0", done_cnt);
        end else $display("reset_no_done: quiet after abort");
    endtask

    task automatic test_basic_frame();
        bus = '0;
        bus[1*RS +: RS] = 32'hDEADBEEF;
        build_exp(bus);
        pulse_start();
        collect(0, -1, 0, 400);
        check_frame("basic_frame");
        vectors++;
        if (got[FLEN-1] !== 8'h22 || got[5] !== 8'hDE || got[8] !== 8'hEF) begin
            miscompares++;
            $display("FAIL basic_bytes: cs=%02h b5=%02h b8=%02h expected 22 DE EF", got[FLEN-1], got[5], got[8]);
        end else $display("basic_bytes: cs=22 b5=DE b8=EF");
        vectors++;
        if (busy_cyc != 130) begin
            miscompares++;
            $display("FAIL basic_busy: %0d cycles expected 130", busy_cyc);
        end else $display("basic_busy: 130 cycles");
        @(posedge clk); @(negedge clk);
        vectors++;
        if (o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: done=%b one cycle later expected 0", o_done);
        end else $display("basic_done_pulse: single cycle");
    endtask

    task automatic test_backpressure();
        for (int j = 0; j < NR; j++) bus[j*RS +: RS] = 32'h11223300 + j;
        build_exp(bus);
        pulse_start();
        collect(1, -1, 0, 600);
        check_frame("backpressure_frame");
        vectors++;
        if (got[FLEN-1] !== 8'h00) begin
            miscompares++;
            $display("FAIL bp_checksum: %02h expected 00", got[FLEN-1]);
        end else $display("bp_checksum: 00");
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable stalls expected 0", unstable);
        end else $display("bp_hold: data stable while stalled");
        vectors++;
        if (busy_cyc != 259) begin
            miscompares++;
            $display("FAIL bp_cycles: %0d busy cycles expected 259", busy_cyc);
        end else $display("bp_cycles: 259");
        i_tx_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        logic [BUS_W-1:0] a;
        for (int j = 0; j < NR; j++) a[j*RS +: RS] = {8'(j), 8'(j) ^ 8'h5A, 8'hC3, ~8'(j)};
        bus = a;
        build_exp(a);
        pulse_start();
        bus = ~a;
        collect(0, -1, 0, 400);
        check_frame("snapshot_frame");
    endtask

    task automatic test_start_ignored();
        int noise;
        for (int j = 0; j < NR; j++) bus[j*RS +: RS] = 32'h01020304 * (j + 1);
        build_exp(bus);
        pulse_start();
        collect(0, 40, 0, 400);
        i_start = 1'b0;
        check_frame("start_mid_frame");
        i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        noise = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_busy || o_tx_valid || o_done) noise++;
        end
        vectors++;
        if (noise != 0) begin
            miscompares++;
            $display("FAIL start_in_done: %0d active cycles expected 0", noise);
        end else $display("start_in_done: ignored");
    endtask

    task automatic test_back_to_back();
        int gap;
        int extra_done;
        for (int j = 0; j < NR; j++) bus[j*RS +: RS] = {8'hF0 ^ 8'(j), 8'(j * 3), 8'h0F, 8'(j * 7)};
        build_exp(bus);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        collect(0, -1, 0, 400);
        check_frame("b2b_frame1");
        gap = 0; extra_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            gap++;
            if (o_done) extra_done++;
            if (o_tx_valid) break;
        end
        i_start = 1'b0;
        vectors++;
        if (gap != 2 || o_tx_data !== 8'hA5 || extra_done != 0) begin
            miscompares++;
            $display("FAIL b2b_gap: gap=%0d data=%02h extra_done=%0d expected 2 A5 0", gap, o_tx_data, extra_done);
        end else $display("b2b_gap: restart after DONE, header A5");
        collect(0, -1, 0, 400);
        check_frame("b2b_frame2");
    endtask

    task automatic test_reset_mid_frame();
        for (int j = 0; j < NR; j++) bus[j*RS +: RS] = 32'h80000001 + (j << 8);
        pulse_start();
        collect(0, -1, 50, 400);
        vectors++;
        if (n_got != 50) begin
            miscompares++;
            $display("FAIL mid_partial: %0d bytes expected 50", n_got);
        end else $display("mid_partial: 50 bytes before reset");
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: %03h expected 000", {o_tx_data, o_tx_valid, o_busy, o_done});
        end else $display("mid_reset_outputs: 0");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < NR; j++) bus[j*RS +: RS] = 32'h0BADF00D ^ (j * 32'h01010101);
        build_exp(bus);
        pulse_start();
        collect(0, -1, 0, 400);
        check_frame("mid_reset_fresh_frame");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_snapshot();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
